arb_req_burst_ctrl: RTL and testbench
=====================================

Name: arb_req_burst_ctrl

Overview:
- Upstream request stage for the 4-way fixed-priority grant FSM.
- Each of four clients issues a one-cycle start pulse with a burst length.
- The block raises and holds that client's req_N line until the granted beats are complete, then drops it and waits for the grant to clear.
- It also produces a per-beat strobe with the source index for the shared-resource datapath, plus per-client busy and done status.

Parameters:
- LEN_W, 4, width of each burst-length input; legal lengths are 1..2^LEN_W-1.

Ports:
- clock  in  1  single clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start_0..start_3  in  1 each  one-cycle burst request from client N.
- len_0..len_3  in  LEN_W each  burst length for client N; sampled only in the cycle start_N is accepted.
- gnt_0..gnt_3  in  1 each  grants from the arbiter.
- req_0..req_3  out  1 each  held requests to the arbiter; registered.
- busy_0..busy_3  out  1 each  client N is not IDLE; registered.
- done_0..done_3  out  1 each  one-cycle pulse when client N's burst fully retires; registered.
- beat_valid  out  1  a granted beat occurs this cycle; combinational.
- beat_src  out  2  index of the client owning the beat; 0 when beat_valid=0.
- protocol_err  out  1  sticky grant-protocol violation flag; registered.

Behaviour:
- Reset values: req_*=0, busy_*=0, done_*=0, protocol_err=0, all channels in IDLE, all counters 0.
- Reset asserted mid-burst aborts everything at once: no done pulse is produced.
- Per-channel FSM with three states: IDLE, ACTIVE, DRAIN.
- IDLE:
  - start_N=1 and len_N!=0 -> ACTIVE; latch len_N; clear the beat counter.
  - start_N with len_N=0 is ignored.
- ACTIVE:
  - req_N=1.
  - A cycle with gnt_N=1 is a beat and increments the counter.
  - The beat where counter==len-1 is the last beat -> DRAIN.
- DRAIN:
  - req_N=0.
  - Grants received in DRAIN are not beats; the arbiter's registered grant lags req.
  - gnt_N=0 -> IDLE, and done_N pulses for exactly one cycle, the first cycle in IDLE.
- req_N and busy_N are registered decodes of the next state:
  - req_N=1 exactly in cycles where the state is ACTIVE.
  - busy_N=1 in ACTIVE and DRAIN.
- start_N while busy_N=1 is ignored and does not queue.
- start_N in the same cycle as done_N=1 is accepted, because the channel is already IDLE.
- Beat outputs:
  - beat_valid = OR over N of (state_N==ACTIVE & gnt_N).
  - beat_src = lowest such N.
- Counter: LEN_W bits; it never wraps, because the channel exits ACTIVE on the last beat.
- protocol_err is set and then held until reset when either:
  - more than one gnt_* is high in the same cycle, or
  - gnt_N=1 while channel N is IDLE.
- Burst length bounds:
  - Minimum length 1: req_N is high for 1 cycle after the grant arrives.
  - Maximum length 2^LEN_W-1.
- Gaps in gnt_N during ACTIVE (grant drops and returns) stall counting; req_N stays high.

Test Plan:
1. Single burst:
   - Stimulus: start_0 with len_0=3; req_0=1 from next cycle; bench drives gnt_0=1 two cycles later for 5 cycles.
   - Response: beat_valid=1 with beat_src=0 for exactly 3 cycles; req_0 falls after the 3rd beat; done_0 pulses once in the cycle after gnt_0 falls; busy_0 then 0.
2. Priority/overlap:
   - Stimulus: start_1 (len 2) and start_3 (len 1) in the same cycle; bench grants 1 then 3 sequentially.
   - Response: 2 beats with src=1, then 1 beat with src=3; both req lines held until served; done_1 precedes done_3.
3. Ignored starts:
   - Stimulus: start_2 with len_2=0, then start_2 (len 2) repeated during ACTIVE.
   - Response: the first produces no req_2; the repeat does not change the length; exactly 2 beats.
4. Grant gap:
   - Stimulus: len_0=4; gnt_0 pattern 1,1,0,0,1,1.
   - Response: counter stalls during the gap; exactly 4 beats; req_0 stays high through the gap.
5. Protocol error:
   - Stimulus: gnt_2=1 while channel 2 is IDLE, or gnt_0 and gnt_1 high together.
   - Response: protocol_err=1 next cycle and remains 1 until reset.
6. Reset mid-burst:
   - Stimulus: assert reset asynchronously between edges during ACTIVE with 2 beats done.
   - Response: req_*/busy_* go to 0 immediately; no done pulse; a new start after reset runs a full burst.

Source files
------------

// File: rtl/arb_req_burst_ctrl.sv
// Upstream request stage for a 4-way fixed-priority grant FSM: holds req_N for a
// client's burst until all granted beats retire, and reports beats and status.
module arb_req_burst_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_0,
  input  logic             start_1,
  input  logic             start_2,
  input  logic             start_3,
  input  logic [LEN_W-1:0] len_0,
  input  logic [LEN_W-1:0] len_1,
  input  logic [LEN_W-1:0] len_2,
  input  logic [LEN_W-1:0] len_3,
  input  logic             gnt_0,
  input  logic             gnt_1,
  input  logic             gnt_2,
  input  logic             gnt_3,
  output logic             req_0,
  output logic             req_1,
  output logic             req_2,
  output logic             req_3,
  output logic             busy_0,
  output logic             busy_1,
  output logic             busy_2,
  output logic             busy_3,
  output logic             done_0,
  output logic             done_1,
  output logic             done_2,
  output logic             done_3,
  output logic             beat_valid,
  output logic [1:0]       beat_src,
  output logic             protocol_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t           state_q [4];
  state_t           state_d [4];
  logic [LEN_W-1:0] len_q   [4];
  logic [LEN_W-1:0] len_d   [4];
  logic [LEN_W-1:0] cnt_q   [4];
  logic [LEN_W-1:0] cnt_d   [4];
  logic [LEN_W-1:0] len_in  [4];
  logic [3:0]       start, gnt, beat, idle;
  logic [3:0]       req_q, busy_q, done_q, done_d;
  logic             err_q, err_d;

  assign start     = {start_3, start_2, start_1, start_0};
  assign gnt       = {gnt_3, gnt_2, gnt_1, gnt_0};
  assign len_in[0] = len_0;
  assign len_in[1] = len_1;
  assign len_in[2] = len_2;
  assign len_in[3] = len_3;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      len_d[n]   = len_q[n];
      cnt_d[n]   = cnt_q[n];
      done_d[n]  = 1'b0;
      idle[n]    = (state_q[n] == IDLE);
      beat[n]    = (state_q[n] == ACTIVE) && gnt[n];
      case (state_q[n])
        IDLE: begin
          if (start[n] && (len_in[n] != '0)) begin
            state_d[n] = ACTIVE;
            len_d[n]   = len_in[n];
            cnt_d[n]   = '0;
          end
        end
        ACTIVE: begin
          if (beat[n]) begin
            cnt_d[n] = cnt_q[n] + LEN_W'(1);
            if (cnt_q[n] == len_q[n] - LEN_W'(1)) state_d[n] = DRAIN;
          end
        end
        DRAIN: begin
          // Arbiter's registered grant lags req; wait for it to clear.
          if (!gnt[n]) begin
            state_d[n] = IDLE;
            done_d[n]  = 1'b1;
          end
        end
        default: state_d[n] = IDLE;
      endcase
    end
  end

  always_comb begin
    beat_src = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (beat[n]) beat_src = 2'(n);
    end
  end

  assign beat_valid = |beat;

  // Sticky: overlapping grants, or a grant to a channel with no burst in flight.
  assign err_d = err_q || ((gnt & (gnt - 4'd1)) != 4'd0) || ((gnt & idle) != 4'd0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= IDLE;
        len_q[n]   <= '0;
        cnt_q[n]   <= '0;
      end
      req_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        len_q[n]   <= len_d[n];
        cnt_q[n]   <= cnt_d[n];
        req_q[n]   <= (state_d[n] == ACTIVE);
        busy_q[n]  <= (state_d[n] != IDLE);
      end
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign {req_3, req_2, req_1, req_0}     = req_q;
  assign {busy_3, busy_2, busy_1, busy_0} = busy_q;
  assign {done_3, done_2, done_1, done_0} = done_q;
  assign protocol_err                     = err_q;

endmodule

// File: tb/tb_arb_req_burst_ctrl.sv
// Directed self-checking bench for arb_req_burst_ctrl: single burst, overlap,
// ignored starts, grant gap, protocol error and mid-burst reset.
module tb_arb_req_burst_ctrl;

  localparam int LEN_W = 4;

  logic clock = 1'b0;
  logic reset;
  logic start_0, start_1, start_2, start_3;
  logic [LEN_W-1:0] len_0, len_1, len_2, len_3;
  logic gnt_0, gnt_1, gnt_2, gnt_3;
  logic req_0, req_1, req_2, req_3;
  logic busy_0, busy_1, busy_2, busy_3;
  logic done_0, done_1, done_2, done_3;
  logic beat_valid;
  logic [1:0] beat_src;
  logic protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  arb_req_burst_ctrl #(.LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .start_0(start_0), .start_1(start_1), .start_2(start_2), .start_3(start_3),
    .len_0(len_0), .len_1(len_1), .len_2(len_2), .len_3(len_3),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2), .gnt_3(gnt_3),
    .req_0(req_0), .req_1(req_1), .req_2(req_2), .req_3(req_3),
    .busy_0(busy_0), .busy_1(busy_1), .busy_2(busy_2), .busy_3(busy_3),
    .done_0(done_0), .done_1(done_1), .done_2(done_2), .done_3(done_3),
    .beat_valid(beat_valid), .beat_src(beat_src), .protocol_err(protocol_err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    {start_0, start_1, start_2, start_3} = '0;
    {gnt_0, gnt_1, gnt_2, gnt_3} = '0;
    len_0 = '0; len_1 = '0; len_2 = '0; len_3 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    n_checks++;
    if ({req_3, req_2, req_1, req_0, busy_3, busy_2, busy_1, busy_0} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_req_busy: got %b expected 00000000",
               {req_3, req_2, req_1, req_0, busy_3, busy_2, busy_1, busy_0});
    end
    n_checks++;
    if ({done_3, done_2, done_1, done_0, protocol_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_done_err: got %b expected 00000",
               {done_3, done_2, done_1, done_0, protocol_err});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_burst();
    int beats = 0;
    start_0 = 1'b1; len_0 = 4'd3;
    tick();
    start_0 = 1'b0;
    n_checks++;
    if (req_0 !== 1'b1 || busy_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_req_rise: req_0=%b busy_0=%b expected 1 1", req_0, busy_0);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      gnt_0 = 1'b1;
      #1;
      n_checks++;
      if (beat_valid !== (i < 3) || req_0 !== (i < 3)) begin
        n_fail++;
        $display("FAIL single_beat[%0d]: beat_valid=%b req_0=%b expected %b", i, beat_valid, req_0, (i < 3));
      end
      if (beat_valid === 1'b1) begin
        beats++;
        n_checks++;
        if (beat_src !== 2'd0) begin
          n_fail++;
          $display("FAIL single_src[%0d]: got %0d expected 0", i, beat_src);
        end
      end
      tick();
    end
    gnt_0 = 1'b0;
    n_checks++;
    if (done_0 !== 1'b0 || busy_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drain: done_0=%b busy_0=%b expected 0 1", done_0, busy_0);
    end
    tick();
    n_checks++;
    if (done_0 !== 1'b1 || busy_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done_0=%b busy_0=%b expected 1 0", done_0, busy_0);
    end
    tick();
    n_checks++;
    if (done_0 !== 1'b0 || beats != 3 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: done_0=%b beats=%0d err=%b expected 0 3 0", done_0, beats, protocol_err);
    end
  endtask

  task automatic test_priority_overlap();
    start_1 = 1'b1; len_1 = 4'd2;
    start_3 = 1'b1; len_3 = 4'd1;
    tick();
    start_1 = 1'b0; start_3 = 1'b0;
    n_checks++;
    if (req_1 !== 1'b1 || req_3 !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_reqs: req_1=%b req_3=%b expected 1 1", req_1, req_3);
    end
    for (int i = 0; i < 2; i++) begin
      gnt_1 = 1'b1;
      #1;
      n_checks++;
      if (beat_valid !== 1'b1 || beat_src !== 2'd1 || req_3 !== 1'b1) begin
        n_fail++;
        $display("FAIL overlap_beat1[%0d]: valid=%b src=%0d req_3=%b expected 1 1 1", i, beat_valid, beat_src, req_3);
      end
      tick();
    end
    gnt_1 = 1'b0; gnt_3 = 1'b1;
    #1;
    n_checks++;
    if (beat_valid !== 1'b1 || beat_src !== 2'd3 || req_1 !== 1'b0 || req_3 !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_beat3: valid=%b src=%0d req_1=%b req_3=%b expected 1 3 0 1",
               beat_valid, beat_src, req_1, req_3);
    end
    tick();
    gnt_3 = 1'b0;
    n_checks++;
    if (done_1 !== 1'b1 || done_3 !== 1'b0 || req_3 !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_done1: done_1=%b done_3=%b req_3=%b expected 1 0 0", done_1, done_3, req_3);
    end
    tick();
    n_checks++;
    if (done_1 !== 1'b0 || done_3 !== 1'b1 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_done3: done_1=%b done_3=%b err=%b expected 0 1 0", done_1, done_3, protocol_err);
    end
    tick();
  endtask

  task automatic test_ignored_starts();
    int beats = 0;
    start_2 = 1'b1; len_2 = 4'd0;
    tick();
    start_2 = 1'b0;
    n_checks++;
    if (req_2 !== 1'b0 || busy_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_len0: req_2=%b busy_2=%b expected 0 0", req_2, busy_2);
    end
    start_2 = 1'b1; len_2 = 4'd2;
    tick();
    len_2 = 4'd7;
    tick();
    start_2 = 1'b0; len_2 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      gnt_2 = 1'b1;
      #1;
      if (beat_valid === 1'b1 && beat_src === 2'd2) beats++;
      tick();
    end
    gnt_2 = 1'b0;
    n_checks++;
    if (beats != 2 || req_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_repeat: beats=%0d req_2=%b expected 2 0", beats, req_2);
    end
    tick();
    n_checks++;
    if (done_2 !== 1'b1 || busy_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done: done_2=%b busy_2=%b expected 1 0", done_2, busy_2);
    end
    tick();
  endtask

  task automatic test_grant_gap();
    logic [5:0] pattern;
    int beats = 0;
    pattern = 6'b110011;
    start_0 = 1'b1; len_0 = 4'd4;
    tick();
    start_0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gnt_0 = pattern[5 - i];
      #1;
      n_checks++;
      if (beat_valid !== pattern[5 - i] || req_0 !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_cycle[%0d]: valid=%b req_0=%b expected %b 1", i, beat_valid, req_0, pattern[5 - i]);
      end
      if (beat_valid === 1'b1) beats++;
      tick();
    end
    gnt_0 = 1'b0;
    n_checks++;
    if (beats != 4 || req_0 !== 1'b0 || busy_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_end: beats=%0d req_0=%b busy_0=%b expected 4 0 1", beats, req_0, busy_0);
    end
    tick();
    n_checks++;
    if (done_0 !== 1'b1 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_done: done_0=%b err=%b expected 1 0", done_0, protocol_err);
    end
    tick();
  endtask

  task automatic test_protocol_error();
    gnt_2 = 1'b1;
    #1;
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_early: got %b expected 0", protocol_err);
    end
    tick();
    gnt_2 = 1'b0;
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_idle_gnt: got %b expected 1", protocol_err);
    end
    tick();
    tick();
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_sticky: got %b expected 1", protocol_err);
    end
    do_reset();
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_cleared: got %b expected 0", protocol_err);
    end
    start_0 = 1'b1; len_0 = 4'd2;
    start_1 = 1'b1; len_1 = 4'd2;
    tick();
    start_0 = 1'b0; start_1 = 1'b0;
    gnt_0 = 1'b1; gnt_1 = 1'b1;
    #1;
    n_checks++;
    if (beat_valid !== 1'b1 || beat_src !== 2'd0) begin
      n_fail++;
      $display("FAIL perr_lowest_src: valid=%b src=%0d expected 1 0", beat_valid, beat_src);
    end
    tick();
    gnt_0 = 1'b0; gnt_1 = 1'b0;
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_multi_gnt: got %b expected 1", protocol_err);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    bit saw_done = 1'b0;
    start_0 = 1'b1; len_0 = 4'd4;
    tick();
    start_0 = 1'b0;
    gnt_0 = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (req_0 !== 1'b0 || busy_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: req_0=%b busy_0=%b expected 0 0", req_0, busy_0);
    end
    gnt_0 = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done_0 !== 1'b0) saw_done = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_done || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_done: saw_done=%b err=%b expected 0 0", saw_done, protocol_err);
    end
    start_0 = 1'b1; len_0 = 4'd2;
    tick();
    start_0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gnt_0 = 1'b1;
      #1;
      if (beat_valid === 1'b1) beats++;
      tick();
    end
    gnt_0 = 1'b0;
    tick();
    n_checks++;
    if (beats != 2 || done_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rerun: beats=%0d done_0=%b expected 2 1", beats, done_0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_priority_overlap();
    test_ignored_starts();
    test_grant_gap();
    test_protocol_error();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
